// File: rtl/sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_lvl
// Description : Single-clock FIFO for same-domain buffering. Supports any
//               depth >= 2, registered-read or show-ahead (FWFT) output,
//               fill-level output, programmable almost-full/almost-empty
//               thresholds, synchronous flush and sticky overflow/underflow
//               error flags.
// Ports       : clk, rst (async, active high)
//               flush                  synchronous clear of contents
//               data_in_vld, data_in   write side; fifo_full
//               read_req               read request / FWFT pop acknowledge
//               data_out_vld, data_out read side; fifo_empty
//               level                  number of stored words
//               af_thresh, ae_thresh   almost-full / almost-empty thresholds
//               almost_full, almost_empty
//               overflow, underflow    sticky errors, cleared by err_clr
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_lvl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int FWFT        = 0,
  parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   data_in_vld,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   fifo_full,
  input  logic                   read_req,
  output logic                   data_out_vld,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   fifo_empty,
  output logic [LEVEL_WIDTH-1:0] level,
  input  logic [LEVEL_WIDTH-1:0] af_thresh,
  input  logic [LEVEL_WIDTH-1:0] ae_thresh,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // All status flags come straight from the level register, so they move
  // in the same cycle as level.
  assign fifo_full    = (level == LVL_FULL);
  assign fifo_empty   = (level == '0);
  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);

  // Acceptance uses pre-edge full/empty: at full a simultaneous write is
  // rejected even though the read frees a slot (and vice versa at empty).
  assign wr_acc = data_in_vld & ~fifo_full  & ~flush;
  assign rd_acc = read_req    & ~fifo_empty & ~flush;

  // Explicit wrap keeps non-power-of-two depths inside 0..FIFO_DEPTH-1.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky errors: a new set event wins over err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (data_in_vld & fifo_full & ~flush) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (read_req & fifo_empty & ~flush) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally whenever the FIFO holds data.
      assign data_out     = mem[rd_ptr];
      assign data_out_vld = ~fifo_empty;
    end else begin : g_reg_read
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out     <= '0;
          data_out_vld <= 1'b0;
        end else if (rd_acc) begin
          data_out     <= mem[rd_ptr];
          data_out_vld <= 1'b1;
        end else begin
          // Covers flush as well: rd_acc is masked by flush.
          data_out     <= '0;
          data_out_vld <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
